// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: HI/LO unit op encodings, sequencer states, default width.
package mips_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on magnitudes.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] operand,
    input  logic              div,
    output logic [DATA_W-1:0] next_acc,
    output logic [DATA_W-1:0] next_quo
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + (quo[0] ? {1'b0, operand} : '0);
        shifted  = {acc, quo[DATA_W-1]};
        diff     = shifted - {1'b0, operand};
        next_acc = sum[DATA_W:1];
        next_quo = {sum[0], quo[DATA_W-1:1]};
        if (div) begin
            // Partial remainder stays below the divisor, so bit DATA_W of diff is the borrow.
            if (!diff[DATA_W]) begin
                next_acc = diff[DATA_W-1:0];
                next_quo = {quo[DATA_W-2:0], 1'b1};
            end else begin
                next_acc = shifted[DATA_W-1:0];
                next_quo = {quo[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the pipeline while busy.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    input  logic              i_hilo_rd,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_t         state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;
    logic              busy;
    logic              done;

    logic              op_md;
    logic              op_div;
    logic              op_signed;
    logic              sign_rs;
    logic              sign_rt;
    logic [DATA_W-1:0] abs_rs;
    logic [DATA_W-1:0] abs_rt;
    logic [DATA_W-1:0] step_acc;
    logic [DATA_W-1:0] step_quo;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0] fix_hi;
    logic [DATA_W-1:0] fix_lo;

    always_comb begin
        op_md     = (i_op == MD_MULT) || (i_op == MD_MULTU) ||
                    (i_op == MD_DIV)  || (i_op == MD_DIVU);
        op_div    = (i_op == MD_DIV)  || (i_op == MD_DIVU);
        op_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
        sign_rs   = op_signed & i_rs[DATA_W-1];
        sign_rt   = op_signed & i_rt[DATA_W-1];
        abs_rs    = sign_rs ? ('0 - i_rs) : i_rs;
        abs_rt    = sign_rt ? ('0 - i_rt) : i_rt;
    end

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc      (acc),
        .quo      (quo),
        .operand  (operand),
        .div      (is_div),
        .next_acc (step_acc),
        .next_quo (step_quo)
    );

    // Sign correction applied once the magnitude iterations are finished.
    always_comb begin
        prod     = {acc, quo};
        prod_fix = neg_q ? ('0 - prod) : prod;
        fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
        fix_lo   = prod_fix[DATA_W-1:0];
        if (is_div) begin
            fix_hi = neg_r ? ('0 - acc) : acc;
            fix_lo = div_zero ? '1 : (neg_q ? ('0 - quo) : quo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc      <= '0;
            quo      <= '0;
            operand  <= '0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE, MD_DONE: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (i_start && !i_flush) begin
                        if (op_md) begin
                            state    <= MD_RUN;
                            busy     <= 1'b1;
                            count    <= CNT_W'(DATA_W - 1);
                            acc      <= '0;
                            quo      <= op_div ? abs_rs : abs_rt;
                            operand  <= op_div ? abs_rt : abs_rs;
                            is_div   <= op_div;
                            neg_q    <= sign_rs ^ sign_rt;
                            neg_r    <= sign_rs;
                            div_zero <= (i_rt == '0);
                        end else if (i_op == MD_MTHI) begin
                            hi <= i_rs;
                        end else if (i_op == MD_MTLO) begin
                            lo <= i_rs;
                        end
                    end
                end
                MD_RUN: begin
                    if (i_flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= step_acc;
                        quo   <= step_quo;
                        count <= count - CNT_W'(1);
                        if (count == '0) begin
                            state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!i_flush) begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        state <= MD_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = busy;
    assign o_stall = busy & (i_start | i_hilo_rd);
    assign o_done  = done;
    assign o_hi    = hi;
    assign o_lo    = lo;

endmodule
